// File: rtl/bcd_counter_pkg.sv
// bcd_counter_pkg
//   Shared constants and types for the BCD counter bank.
//   DIGIT_W    : bits per BCD digit
//   BCD_MAX    : largest legal digit value
//   MAX_DIGITS : largest supported bank width (ripple must fit the inc->ref window)
//   state_t    : ripple controller states
package bcd_counter_pkg;

    localparam int DIGIT_W    = 4;
    localparam int BCD_MAX    = 9;
    localparam int MAX_DIGITS = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RIPPLE = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
//   Combinational single-digit BCD adder: digit + add bit + carry-in.
//   Ports:
//     i_digit  : current BCD digit (0..9)
//     i_add    : add-one request for this digit
//     i_carry  : carry from the digit below
//     o_digit  : resulting BCD digit
//     o_carry  : carry into the digit above
module bcd_digit_add
    import bcd_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_add,
    input  logic               i_carry,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_carry
);

    logic [DIGIT_W:0] w_sum;

    always_comb begin
        w_sum   = {1'b0, i_digit} + {{DIGIT_W{1'b0}}, i_add} + {{DIGIT_W{1'b0}}, i_carry};
        o_digit = w_sum[DIGIT_W-1:0];
        o_carry = 1'b0;
        if (w_sum > (DIGIT_W+1)'(BCD_MAX)) begin
            o_digit = DIGIT_W'(w_sum - (DIGIT_W+1)'(BCD_MAX + 1));
            o_carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_counter_bank.sv
// bcd_counter_bank
//   Bank of DIGITS BCD digits. An inc_clk pulse adds 1 to every digit whose
//   trigger bit is set; carries ripple one digit per clock through a single
//   shared digit adder. A ref_clk pulse copies the working digits into the
//   display register; a refresh that arrives mid-ripple is held and applied
//   in the first idle cycle so partial results are never shown.
//   Optional feature: define BCD_OVERFLOW_EN for a sticky overflow flag.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     inc_clk     : one-cycle increment request (ignored while busy)
//     ref_clk     : one-cycle refresh request
//     trigger     : per-digit add mask, sampled with inc_clk
//     digits_out  : latched display value, digit k at [4k+3:4k]
//     disp_stb    : pulse in the cycle digits_out shows a new latch
//     busy        : carry ripple in progress
//     overflow    : sticky carry-out of the top digit (0 without the macro)
//   DIGITS must be in 1..MAX_DIGITS.
module bcd_counter_bank
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inc_clk,
    input  logic                      ref_clk,
    input  logic [DIGITS-1:0]         trigger,
    output logic [DIGIT_W*DIGITS-1:0] digits_out,
    output logic                      disp_stb,
    output logic                      busy,
    output logic                      overflow
);

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [DIGITS-1:0][DIGIT_W-1:0]  r_cnt;
    logic [DIGITS-1:0][DIGIT_W-1:0]  r_disp;
    logic [DIGITS-1:0]               r_pend;
    logic                            r_carry;
    logic [IDX_W-1:0]                r_idx;
    logic                            r_ref_pend;
    logic                            r_disp_stb;

    logic                            w_last;
    logic                            w_start;
    logic                            w_latch;
    logic [DIGIT_W-1:0]              w_digit;
    logic                            w_carry;

    assign w_last  = (r_idx == LAST_IDX);
    assign w_start = (r_state == ST_IDLE) && inc_clk;
    // A deferred refresh is served on the first idle cycle; when inc_clk
    // coincides, the pre-increment value is latched since cnt is not yet touched.
    assign w_latch = (r_state == ST_IDLE) && (ref_clk || r_ref_pend);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (inc_clk) w_state_nxt = ST_RIPPLE;
            ST_RIPPLE: if (w_last)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // One adder shared by all digits, steered by the ripple index.
    bcd_digit_add u_add (
        .i_digit (r_cnt[r_idx]),
        .i_add   (r_pend[r_idx]),
        .i_carry (r_carry),
        .o_digit (w_digit),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_pend  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_start) begin
            r_pend  <= trigger;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == ST_RIPPLE) begin
            r_cnt[r_idx] <= w_digit;
            r_carry      <= w_carry;
            if (!w_last) r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp     <= '0;
            r_disp_stb <= 1'b0;
            r_ref_pend <= 1'b0;
        end else begin
            r_disp_stb <= w_latch;
            if (w_latch) r_disp <= r_cnt;
            if ((r_state == ST_RIPPLE) && ref_clk) r_ref_pend <= 1'b1;
            else if (w_latch)                      r_ref_pend <= 1'b0;
        end
    end

`ifdef BCD_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (reset)                                            r_overflow <= 1'b0;
        else if ((r_state == ST_RIPPLE) && w_last && w_carry) r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign digits_out = r_disp;
    assign disp_stb   = r_disp_stb;
    assign busy       = (r_state == ST_RIPPLE);

endmodule
